reset_release_monitor: RTL

- Consumer-side checker for the distributed reset tree.
- Watches N active-low reset copies, each already synchronous to the clock, as they deassert after a board reset.
- Measures skew: clock cycles from the first to the last deassertion. Flags skew above a limit, a never-completing release (timeout) and a re-assertion during release (glitch).
- Sits beside the reset generator and the counter bank. Its outputs drive LEDs or debug registers.

---
 rtl/reset_release_monitor_if.sv | 33 +++
 rtl/reset_release_monitor.sv | 120 ++++++++++++
 2 files changed

// File: rtl/reset_release_monitor_if.sv
// Signal bundle between a reset-tree source and reset_release_monitor.
//   rst_n_in   : N monitored active-low resets, already synchronous to the clock
//   clear      : synchronous clear of results and FSM
//   skew_count : cycles from first to last deassertion, saturating
//   first_mask : copies already released on the first-release edge
//   done       : a complete release has been measured
//   skew_err   : skew_count above the accepted limit
//   timeout    : counter saturated before every copy released
//   glitch     : sticky, a copy re-asserted during release
// master drives the monitored resets and clear; slave is the monitor.
interface reset_release_monitor_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic [N-1:0]     rst_n_in;
    logic             clear;
    logic [CNT_W-1:0] skew_count;
    logic [N-1:0]     first_mask;
    logic             done;
    logic             skew_err;
    logic             timeout;
    logic             glitch;

    modport master (
        output rst_n_in, clear,
        input  skew_count, first_mask, done, skew_err, timeout, glitch
    );

    modport slave (
        input  rst_n_in, clear,
        output skew_count, first_mask, done, skew_err, timeout, glitch
    );
endinterface

// File: rtl/reset_release_monitor.sv
// Consumer-side checker for a distributed reset tree. Waits for every
// monitored copy to be asserted, then measures the cycles between the first
// and the last deassertion and flags excessive skew, a release that never
// completes, and re-assertion while the release is in progress.
//   clock : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : reset_release_monitor_if.slave (monitored resets, clear, results)
module reset_release_monitor #(
    parameter int N        = 4,
    parameter int CNT_W    = 8,
    parameter int MAX_SKEW = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    reset_release_monitor_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        MEASURE,
        DONE
    } state_t;

    localparam logic [N-1:0]     ALL_ONE = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [N-1:0]     seen;      // copies released so far in this measurement
    logic [CNT_W-1:0] cnt_inc;
    logic [N-1:0]     in;

    assign in      = bus.rst_n_in;
    assign cnt_inc = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;

    // NOTE: every register here is assigned with <= so all updates take the
    // values sampled at the same edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset || bus.clear) begin
            state          <= IDLE;
            cnt            <= '0;
            seen           <= '0;
            bus.skew_count <= '0;
            bus.first_mask <= '0;
            bus.done       <= 1'b0;
            bus.skew_err   <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.glitch     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in == '0) begin
                        state        <= ARMED;
                        bus.done     <= 1'b0;
                        bus.skew_err <= 1'b0;
                        bus.timeout  <= 1'b0;
                    end
                end

                ARMED: begin
                    if (in == ALL_ONE) begin
                        // Whole tree released on one edge: zero skew.
                        bus.first_mask <= ALL_ONE;
                        bus.skew_count <= '0;
                        bus.skew_err   <= (32'd0 > 32'(MAX_SKEW));
                        bus.done       <= 1'b1;
                        state          <= DONE;
                    end else if (in != '0) begin
                        bus.first_mask <= in;
                        seen           <= in;
                        cnt            <= '0;
                        state          <= MEASURE;
                    end
                end

                MEASURE: begin
                    if ((seen & ~in) != '0) begin
                        // A released copy went back into reset.
                        bus.glitch <= 1'b1;
                        bus.done   <= 1'b0;
                        state      <= IDLE;
                    end else if (in == ALL_ONE) begin
                        // Completion wins over saturation on the same edge.
                        bus.skew_count <= cnt_inc;
                        bus.skew_err   <= (32'(cnt_inc) > 32'(MAX_SKEW));
                        bus.done       <= 1'b1;
                        state          <= DONE;
                    end else if (cnt_inc == CNT_MAX) begin
                        bus.skew_count <= CNT_MAX;
                        bus.timeout    <= 1'b1;
                        bus.skew_err   <= 1'b1;
                        bus.done       <= 1'b1;
                        state          <= DONE;
                    end else begin
                        cnt  <= cnt_inc;
                        seen <= seen | in;
                    end
                end

                DONE: begin
                    if (in == '0) begin
                        // New board reset: re-arm, keep the last count visible.
                        bus.done     <= 1'b0;
                        bus.skew_err <= 1'b0;
                        bus.timeout  <= 1'b0;
                        state        <= ARMED;
                    end else if (in != ALL_ONE) begin
                        bus.glitch <= 1'b1;
                        bus.done   <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
